// File: rtl/perf_pkg.sv
// -----------------------------------------------------------------------------
// perf_pkg
// Shared definitions for the pipeline performance monitor:
//   - state_e        : monitor FSM states (IDLE / RUN / FROZEN)
//   - SEL_*          : read-select codes for the rd_sel_i port
//   - SAT_MAX        : all-ones saturation value, sliced to each counter width
// -----------------------------------------------------------------------------
package perf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2
    } state_e;

    localparam logic [2:0] SEL_CYCLES     = 3'd0;
    localparam logic [2:0] SEL_STALLS     = 3'd1;
    localparam logic [2:0] SEL_FLUSHES    = 3'd2;
    localparam logic [2:0] SEL_RETIRED    = 3'd3;
    localparam logic [2:0] SEL_TRACE_POP  = 3'd4;
    localparam logic [2:0] SEL_TRACE_STAT = 3'd5;

    // Widest counter supported; narrower counters take the low bits.
    localparam int unsigned              MAX_CNT_W = 64;
    localparam logic [MAX_CNT_W-1:0]     SAT_MAX   = '1;

endpackage

// File: rtl/pipe_perf_monitor_if.sv
// -----------------------------------------------------------------------------
// pipe_perf_monitor_if
// Bundles the core status inputs and the counter read port of the monitor.
//   master : the side driving core status and read requests (core / bench)
//   slave  : the monitor itself
// Signals: start_i, clear_i, stall_i, branch_i, flush_i, retire_i, pc_i[31:0],
//          rd_en_i, rd_sel_i[2:0]  -> monitor
//          rd_data_o[CNT_W-1:0], rd_valid_o, frozen_o  <- monitor
// -----------------------------------------------------------------------------
interface pipe_perf_monitor_if #(
    parameter int CNT_W = 32
);
    logic             start_i;
    logic             clear_i;
    logic             stall_i;
    logic             branch_i;
    logic             flush_i;
    logic             retire_i;
    logic [31:0]      pc_i;
    logic             rd_en_i;
    logic [2:0]       rd_sel_i;
    logic [CNT_W-1:0] rd_data_o;
    logic             rd_valid_o;
    logic             frozen_o;

    modport master (
        output start_i, clear_i, stall_i, branch_i, flush_i, retire_i, pc_i,
               rd_en_i, rd_sel_i,
        input  rd_data_o, rd_valid_o, frozen_o
    );

    modport slave (
        input  start_i, clear_i, stall_i, branch_i, flush_i, retire_i, pc_i,
               rd_en_i, rd_sel_i,
        output rd_data_o, rd_valid_o, frozen_o
    );
endinterface

// File: rtl/perf_sat_counter.sv
// -----------------------------------------------------------------------------
// perf_sat_counter
// CNT_W-wide event counter that sticks at all-ones instead of wrapping.
// Ports: clk_i, rst_i (async, active-low), clear_i (sync, wins over inc_i),
//        inc_i (count one event), count_o (current value).
// -----------------------------------------------------------------------------
module perf_sat_counter
    import perf_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] MAX_VAL = SAT_MAX[CNT_W-1:0];

    logic [CNT_W-1:0] count_q, count_d;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != MAX_VAL)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipe_perf_monitor.sv
// -----------------------------------------------------------------------------
// pipe_perf_monitor
// Counts cycles, stalls (stall without branch-in-ID), flushes and retired
// writebacks while the core runs; freezes when the cycle count reaches
// CYCLE_LIMIT (0 = never). Counters are read through a one-cycle registered
// select/read port; the read returns the value before any same-edge update.
// Ports: clk_i, rst_i (async, active-low), bus_io (pipe_perf_monitor_if.slave).
// Optional: define PERF_FLUSH_TRACE_EN to record the PC of every counted flush
// in a TRACE_DEPTH-entry FIFO, popped with select 4, status on select 5.
// -----------------------------------------------------------------------------
module pipe_perf_monitor
    import perf_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int CYCLE_LIMIT = 64,
    parameter int TRACE_DEPTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    pipe_perf_monitor_if.slave    bus_io
);

    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(CYCLE_LIMIT - 1);

    state_e           state_q, state_d;
    logic             count_en;
    logic             hit_limit;
    logic [CNT_W-1:0] cyc_cnt, stall_cnt, flush_cnt, ret_cnt;
    logic [CNT_W-1:0] rd_mux;
    logic [CNT_W-1:0] rd_data_q;
    logic             rd_valid_q;

    // The edge that enters RUN already counts, so IDLE and RUN both count
    // whenever start_i is high; FROZEN and a pending clear never count.
    assign count_en  = bus_io.start_i && !bus_io.clear_i && (state_q != ST_FROZEN);
    // Freeze on the edge where the cycle counter steps onto the limit.
    assign hit_limit = (CYCLE_LIMIT != 0) && count_en && (cyc_cnt == LIMIT_M1);

    always_comb begin
        state_d = state_q;
        if (bus_io.clear_i) begin
            state_d = ST_IDLE;
        end else if (hit_limit) begin
            state_d = ST_FROZEN;
        end else begin
            case (state_q)
                ST_IDLE:   if (bus_io.start_i)  state_d = ST_RUN;
                ST_RUN:    if (!bus_io.start_i) state_d = ST_IDLE;
                default:   state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    perf_sat_counter #(.CNT_W(CNT_W)) u_cyc (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(bus_io.clear_i),
        .inc_i(count_en), .count_o(cyc_cnt));

    perf_sat_counter #(.CNT_W(CNT_W)) u_stall (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(bus_io.clear_i),
        .inc_i(count_en && bus_io.stall_i && !bus_io.branch_i), .count_o(stall_cnt));

    perf_sat_counter #(.CNT_W(CNT_W)) u_flush (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(bus_io.clear_i),
        .inc_i(count_en && bus_io.flush_i), .count_o(flush_cnt));

    perf_sat_counter #(.CNT_W(CNT_W)) u_ret (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(bus_io.clear_i),
        .inc_i(count_en && bus_io.retire_i), .count_o(ret_cnt));

`ifdef PERF_FLUSH_TRACE_EN
    localparam int PTR_W = $clog2(TRACE_DEPTH);

    logic [31:0]    trace_mem_q [TRACE_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0] trace_cnt_q;
    logic           ovf_q;
    logic           trace_full, trace_push, trace_pop, push_ok;
    logic [CNT_W-1:0] trace_head, trace_stat;

    assign trace_full = (trace_cnt_q == (PTR_W+1)'(TRACE_DEPTH));
    assign trace_push = count_en && bus_io.flush_i;
    assign trace_pop  = bus_io.rd_en_i && (bus_io.rd_sel_i == SEL_TRACE_POP) &&
                        (trace_cnt_q != '0) && !bus_io.clear_i;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push_ok    = trace_push && (!trace_full || trace_pop);

    assign trace_head = (trace_cnt_q == '0) ? '0 : CNT_W'(trace_mem_q[rd_ptr_q]);

    always_comb begin
        trace_stat            = CNT_W'(trace_cnt_q);
        trace_stat[CNT_W-1]   = trace_stat[CNT_W-1] | ovf_q;
    end

    // NOTE: the storage array has no reset; occupancy is tracked by the reset pointers.
    always_ff @(posedge clk_i) begin
        if (push_ok) trace_mem_q[wr_ptr_q] <= bus_io.pc_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            trace_cnt_q <= '0;
            ovf_q       <= 1'b0;
        end else if (bus_io.clear_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            trace_cnt_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            if (push_ok)   wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (trace_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push_ok && !trace_pop)      trace_cnt_q <= trace_cnt_q + (PTR_W+1)'(1);
            else if (!push_ok && trace_pop) trace_cnt_q <= trace_cnt_q - (PTR_W+1)'(1);
            if (trace_push && !push_ok)     ovf_q <= 1'b1;
        end
    end
`else
    logic unused_trace;
    assign unused_trace = ^{bus_io.pc_i, TRACE_DEPTH[0]};
`endif

    always_comb begin
        rd_mux = '0;
        case (bus_io.rd_sel_i)
            SEL_CYCLES:     rd_mux = cyc_cnt;
            SEL_STALLS:     rd_mux = stall_cnt;
            SEL_FLUSHES:    rd_mux = flush_cnt;
            SEL_RETIRED:    rd_mux = ret_cnt;
`ifdef PERF_FLUSH_TRACE_EN
            SEL_TRACE_POP:  rd_mux = trace_head;
            SEL_TRACE_STAT: rd_mux = trace_stat;
`else
            SEL_TRACE_POP, SEL_TRACE_STAT: rd_mux = '0;
`endif
            default:        rd_mux = '0;
        endcase
    end

    // Read data is sampled from the pre-update counters and is not touched
    // by clear_i, so a read concurrent with a clear returns the old value.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= bus_io.rd_en_i;
            if (bus_io.rd_en_i) rd_data_q <= rd_mux;
        end
    end

    assign bus_io.rd_data_o  = rd_data_q;
    assign bus_io.rd_valid_o = rd_valid_q;
    assign bus_io.frozen_o   = (state_q == ST_FROZEN);

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// -----------------------------------------------------------------------------
// tb_pipe_perf_monitor
// Drives the monitor with directed and random core-status traffic and compares
// every cycle against an event-level reference model. A second, 4-bit instance
// with no cycle limit exercises saturation.
// -----------------------------------------------------------------------------
module tb_pipe_perf_monitor;

    localparam int  LIMIT = 64;
    localparam int  DEPTH = 8;
    localparam longint MAXV = 64'hFFFF_FFFF;
`ifdef PERF_FLUSH_TRACE_EN
    localparam bit  TRACE = 1'b1;
`else
    localparam bit  TRACE = 1'b0;
`endif

    logic clk;
    logic rst_n;

    int n_cmp = 0;
    int n_err = 0;

    pipe_perf_monitor_if #(.CNT_W(32)) m_if ();
    pipe_perf_monitor_if #(.CNT_W(4))  s_if ();

    pipe_perf_monitor #(.CNT_W(32), .CYCLE_LIMIT(LIMIT), .TRACE_DEPTH(DEPTH)) u_dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus_io(m_if.slave)
    );

    pipe_perf_monitor #(.CNT_W(4), .CYCLE_LIMIT(0), .TRACE_DEPTH(DEPTH)) u_small (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus_io(s_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: counts indexed by read select, frozen flag, trace queue.
    longint      m_cnt [4];
    bit          m_frozen;
    logic [31:0] m_q [$];
    bit          m_ovf;
    logic [31:0] exp_data;
    bit          exp_valid;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint sat(input longint v);
        return (v > MAXV) ? MAXV : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        m_frozen  = 1'b0;
        m_q.delete();
        m_ovf     = 1'b0;
        exp_data  = '0;
        exp_valid = 1'b0;
    endtask

    // One clock edge: derive the expected read result from the model state
    // before the edge, apply the event rules, then compare after the edge.
    task automatic tick();
        bit pop_now;
        bit counting;
        int sel;
        sel = int'(m_if.rd_sel_i);
        exp_valid = m_if.rd_en_i;
        if (m_if.rd_en_i) begin
            if (sel < 4)                exp_data = m_cnt[sel][31:0];
            else if (sel == 4 && TRACE) exp_data = (m_q.size() > 0) ? m_q[0] : 32'h0;
            else if (sel == 5 && TRACE) exp_data = {m_ovf, 31'(m_q.size())};
            else                        exp_data = 32'h0;
        end
        pop_now = TRACE && m_if.rd_en_i && (sel == 4) && (m_q.size() > 0);

        if (m_if.clear_i) begin
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            m_frozen = 1'b0;
            m_q.delete();
            m_ovf = 1'b0;
        end else begin
            if (pop_now) void'(m_q.pop_front());
            counting = m_if.start_i && !m_frozen;
            if (counting) begin
                m_cnt[0] = sat(m_cnt[0] + 1);
                if (m_if.stall_i && !m_if.branch_i) m_cnt[1] = sat(m_cnt[1] + 1);
                if (m_if.flush_i)  m_cnt[2] = sat(m_cnt[2] + 1);
                if (m_if.retire_i) m_cnt[3] = sat(m_cnt[3] + 1);
                if (TRACE && m_if.flush_i) begin
                    if (m_q.size() < DEPTH) m_q.push_back(m_if.pc_i);
                    else                    m_ovf = 1'b1;
                end
                if (m_cnt[0] == LIMIT) m_frozen = 1'b1;
            end
        end

        @(posedge clk);
        #1;
        chk("rd_valid", {63'b0, m_if.rd_valid_o}, {63'b0, exp_valid});
        chk("rd_data",  {32'b0, m_if.rd_data_o},  {32'b0, exp_data});
        chk("frozen",   {63'b0, m_if.frozen_o},   {63'b0, m_frozen});
    endtask

    task automatic rd(input logic [2:0] sel, input logic [31:0] exp, input string tag);
        m_if.rd_en_i  = 1'b1;
        m_if.rd_sel_i = sel;
        tick();
        chk(tag, {32'b0, m_if.rd_data_o}, {32'b0, exp});
        chk({tag, "_valid"}, {63'b0, m_if.rd_valid_o}, 64'd1);
        m_if.rd_en_i  = 1'b0;
        m_if.rd_sel_i = 3'd0;
    endtask

    task automatic idle_inputs();
        m_if.start_i  = 0; m_if.clear_i = 0; m_if.stall_i = 0; m_if.branch_i = 0;
        m_if.flush_i  = 0; m_if.retire_i = 0; m_if.pc_i = '0;
        m_if.rd_en_i  = 0; m_if.rd_sel_i = '0;
    endtask

    task automatic do_clear();
        m_if.clear_i = 1'b1;
        tick();
        m_if.clear_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        s_if.start_i = 0; s_if.clear_i = 0; s_if.stall_i = 0; s_if.branch_i = 0;
        s_if.flush_i = 0; s_if.retire_i = 0; s_if.pc_i = '0;
        s_if.rd_en_i = 0; s_if.rd_sel_i = '0;
        model_reset();

        // Reset state.
        #12;
        chk("rst_rd_data",  {32'b0, m_if.rd_data_o}, 64'd0);
        chk("rst_rd_valid", {63'b0, m_if.rd_valid_o}, 64'd0);
        chk("rst_frozen",   {63'b0, m_if.frozen_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Ten running cycles, no events.
        m_if.start_i = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        m_if.start_i = 1'b0;
        rd(3'd0, 32'd10, "cycles10");
        tick();
        chk("valid_one_cycle", {63'b0, m_if.rd_valid_o}, 64'd0);
        rd(3'd1, 32'd0, "stalls0");
        rd(3'd2, 32'd0, "flushes0");
        rd(3'd3, 32'd0, "retired0");

        // Stalls only count without a branch in ID.
        do_clear();
        m_if.start_i = 1'b1;
        m_if.stall_i = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        m_if.branch_i = 1'b1;
        for (int k = 0; k < 2; k++) tick();
        idle_inputs();
        rd(3'd1, 32'd3, "stalls3");
        rd(3'd0, 32'd5, "cycles5");

        // Cycle limit freezes counting.
        do_clear();
        m_if.start_i  = 1'b1;
        m_if.retire_i = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (k == 63) chk("frozen_at63", {63'b0, m_if.frozen_o}, 64'd0);
            if (k == 64) chk("frozen_at64", {63'b0, m_if.frozen_o}, 64'd1);
        end
        idle_inputs();
        rd(3'd0, 32'd64, "cycles_lim");
        rd(3'd3, 32'd64, "retired_lim");
        do_clear();
        chk("frozen_cleared", {63'b0, m_if.frozen_o}, 64'd0);
        for (int s = 0; s < 4; s++) rd(3'(s), 32'd0, "cleared");

        // Read concurrent with clear returns the pre-clear value.
        m_if.start_i = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        m_if.start_i = 1'b0;
        m_if.clear_i = 1'b1;
        rd(3'd0, 32'd4, "rd_with_clear");
        m_if.clear_i = 1'b0;
        rd(3'd0, 32'd0, "after_clear");

        // Saturation on the 4-bit instance.
        s_if.start_i  = 1'b1;
        s_if.retire_i = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        s_if.start_i  = 1'b0;
        s_if.retire_i = 1'b0;
        s_if.rd_en_i  = 1'b1;
        s_if.rd_sel_i = 3'd3;
        tick();
        chk("sat_retired", {60'b0, s_if.rd_data_o}, 64'd15);
        chk("sat_valid",   {63'b0, s_if.rd_valid_o}, 64'd1);
        s_if.rd_en_i  = 1'b0;

        // Asynchronous reset mid-run.
        do_clear();
        m_if.start_i = 1'b1;
        m_if.flush_i = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        m_if.start_i = 1'b0;
        m_if.flush_i = 1'b0;
        rd(3'd2, 32'd5, "flushes5");
        m_if.start_i = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rd_data", {32'b0, m_if.rd_data_o}, 64'd0);
        chk("async_frozen",  {63'b0, m_if.frozen_o}, 64'd0);
        model_reset();
        m_if.start_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rd(3'd2, 32'd0, "flushes_after_rst");

        // Flush trace.
        m_if.start_i = 1'b1;
        m_if.flush_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            m_if.pc_i = 32'h100 + 32'(4 * k);
            tick();
        end
        idle_inputs();
        rd(3'd2, 32'd10, "flushes10");
`ifdef PERF_FLUSH_TRACE_EN
        rd(3'd5, 32'h8000_0008, "trace_stat");
        for (int i = 0; i < 9; i++)
            rd(3'd4, (i < 8) ? 32'h100 + 32'(4 * i) : 32'h0, "trace_pop");
        rd(3'd5, 32'h8000_0000, "trace_stat_empty");
`else
        rd(3'd4, 32'd0, "sel4_zero");
        rd(3'd5, 32'd0, "sel5_zero");
`endif
        rd(3'd6, 32'd0, "sel6_zero");
        rd(3'd7, 32'd0, "sel7_zero");

        // Random traffic against the model.
        do_clear();
        for (int k = 0; k < 600; k++) begin
            m_if.start_i  = ($urandom_range(7) != 0);
            m_if.clear_i  = ($urandom_range(59) == 0);
            m_if.stall_i  = 1'($urandom);
            m_if.branch_i = 1'($urandom);
            m_if.flush_i  = 1'($urandom);
            m_if.retire_i = 1'($urandom);
            m_if.pc_i     = $urandom & 32'hFFFF_FFFC;
            m_if.rd_en_i  = 1'($urandom);
            m_if.rd_sel_i = 3'($urandom_range(7));
            tick();
        end
        idle_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_perf_monitor.md
Name: pipe_perf_monitor

Overview:
- Event-counting monitor that sits directly downstream of the pipelined CPU core.
- Consumes the core's per-cycle hazard and branch status: stall, branch-in-ID, flush, writeback-retire.
- Keeps cycle, stall, flush and retire counts in hardware, replacing ad-hoc counting in the bench.
- Counters are read through a registered select/read port; run is bounded by a cycle limit.

Parameters:
- CNT_W, 32, width of every counter and of rd_data_o.
- CYCLE_LIMIT, 64, cycle count at which counting freezes; 0 = unlimited.
- TRACE_DEPTH, 8, flush-PC trace FIFO depth (power of 2; used only with PERF_FLUSH_TRACE_EN).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  core start; counting enabled while high.
- clear_i  in  1  synchronous clear of all counters; returns FSM to IDLE.
- stall_i  in  1  hazard unit stall request.
- branch_i  in  1  control-unit branch decode in ID.
- flush_i  in  1  taken branch (IF flush) this cycle.
- retire_i  in  1  MEM/WB stage holds a valid writeback (RegWrite).
- pc_i  in  32  current PC.
- rd_en_i  in  1  read request.
- rd_sel_i  in  3  0=cycles, 1=stalls, 2=flushes, 3=retired, 4=trace pop, 5=trace status, 6/7 read 0.
- rd_data_o  out  CNT_W  read data.
- rd_valid_o  out  1  rd_data_o valid.
- frozen_o  out  1  high in FROZEN state.

Behaviour:
- Reset (rst_i=0, async): all counters 0, FSM=IDLE, rd_data_o=0, rd_valid_o=0, frozen_o=0, trace empty.
- FSM states: IDLE, RUN, FROZEN.
  - IDLE->RUN when start_i=1.
  - RUN->IDLE when start_i=0; counters hold.
  - RUN->FROZEN on the edge where cycle count becomes CYCLE_LIMIT (CYCLE_LIMIT!=0).
  - FROZEN exits only via clear_i or reset.
  - clear_i has priority over all events and forces IDLE with counters 0.
- Counting happens in RUN only, one update per edge:
  - cycles +1 every cycle.
  - stalls +1 when stall_i & ~branch_i.
  - flushes +1 when flush_i.
  - retired +1 when retire_i.
  - Simultaneous events each increment their own counter in the same cycle.
- Events on the edge that enters RUN are counted; events on the edge that enters FROZEN are counted; nothing is counted after that.
- Saturation: every counter stops at 2^CNT_W-1, no wrap.
- Read latency is 1 cycle:
  - rd_en_i sampled at edge N gives rd_data_o/rd_valid_o at edge N (registered outputs), valid for exactly one cycle.
  - rd_valid_o is 0 when rd_en_i was 0.
  - rd_data_o holds its last value when not reading.
  - Read data is the counter value before any same-edge increment.
- A read concurrent with clear_i returns the pre-clear value.
- Reads are legal in every state.

Optional Feature:
- Macro: PERF_FLUSH_TRACE_EN.
- Defined:
  - Every counted flush pushes pc_i into a TRACE_DEPTH-entry circular FIFO.
  - rd_sel_i=4 with rd_en_i returns the oldest entry and pops it; pop when empty returns 0 and does not pop.
  - rd_sel_i=5 returns {sticky overflow bit at bit CNT_W-1, entry count in LSBs}.
  - Push when full drops the new PC and sets the sticky overflow bit.
  - Simultaneous push and pop when full: the pop happens and the push is accepted, no overflow.
  - clear_i empties the FIFO and clears overflow.
- Undefined: no FIFO storage; selects 4 and 5 read 0.

Decomposition:
- Package perf_pkg holds:
  - the FSM state enum (IDLE/RUN/FROZEN);
  - read-select constants SEL_CYCLES..SEL_TRACE_STAT;
  - the saturating max constant.
- One sub-module: perf_sat_counter (CNT_W-wide saturating counter with inc/clear), instantiated 4 times.
- The trace FIFO stays inline, under the macro.

Test Plan:
- Reset then start_i=1 for 10 cycles, no events -> read sel0 = 10, sel1-3 = 0, rd_valid_o high exactly 1 cycle after rd_en_i.
- 3 cycles stall_i=1 with branch_i=0, plus 2 cycles stall_i=1 with branch_i=1 -> stalls = 3.
- CYCLE_LIMIT=64, start held 100 cycles with retire_i=1 throughout -> frozen_o rises at cycle 64, cycles = 64, retired = 64; clear_i -> all reads 0, IDLE.
- CNT_W=4, retire_i held 20 cycles -> retired = 15 (saturated, no wrap).
- rst_i pulsed low mid-run after 5 flushes -> outputs 0 immediately (asynchronous), flushes reads 0 after release.
- With PERF_FLUSH_TRACE_EN, 10 flushes at pc_i=0x100+4k -> status = overflow 1, count 8; pops return 0x100, 0x104, ... 0x11C, then the 9th pop returns 0.
